// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel,
// decode-side instruction channel and the branch/jump redirect.
interface instr_fetch_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, single-outstanding imem requests, response buffer.
// Optional FETCH_BYPASS_EN: kept response goes straight to decode when the buffer is empty.
module instr_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  // One slot beyond BUF_DEPTH lands the response of the request issued
  // while the last regular slot was being filled.
  localparam int unsigned SLOTS = BUF_DEPTH + 1;
  localparam int unsigned PTR_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);

`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] pending_pc;
  entry_t                buf_mem [SLOTS];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      cnt_after_pop;

  logic buf_valid;
  logic resp_kept;
  logic bypass;
  logic buf_pop;
  logic push;
  logic free_slot;
  logic req_valid;
  logic req_fire;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and buffer control
  always_comb begin
    buf_valid     = (count != '0) && !rst;
    resp_kept     = (state == S_WAIT) && bus.imem_resp_valid;
    bypass        = BYPASS && !buf_valid && resp_kept && !bus.redirect && !rst;
    buf_pop       = buf_valid && bus.instr_ready;
    push          = resp_kept && !(bypass && bus.instr_ready);
    cnt_after_pop = count - CNT_W'(buf_pop);
    free_slot     = cnt_after_pop < CNT_W'(BUF_DEPTH);
    req_valid     = !rst && !bus.redirect &&
                    ((state == S_FETCH) || resp_kept) && free_slot;
    req_fire      = req_valid && bus.imem_req_ready;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc;

  // Decode-side outputs: buffer head, or the live response when bypassing
  always_comb begin
    bus.instr_valid = buf_valid;
    bus.instr       = buf_valid ? buf_mem[rd_ptr].data : '0;
    bus.instr_pc    = buf_valid ? buf_mem[rd_ptr].pc   : '0;
    if (bypass) begin
      bus.instr_valid = 1'b1;
      bus.instr       = bus.imem_resp_data;
      bus.instr_pc    = pending_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr] <= '{pc: pending_pc, data: bus.imem_resp_data};
    end
  end

  // FSM, PC and buffer pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ~DATA_WIDTH'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A response landing now resolves the outstanding request; otherwise drain it.
      if (bus.imem_resp_valid) begin
        state <= S_FETCH;
      end else if (state != S_FETCH) begin
        state <= S_DRAIN;
      end
    end else begin
      if (req_fire) begin
        fetch_pc   <= fetch_pc + DATA_WIDTH'(4);
        pending_pc <= fetch_pc;
      end
      case (state)
        S_FETCH: if (req_fire) state <= S_WAIT;
        S_WAIT:  if (bus.imem_resp_valid) state <= req_fire ? S_WAIT : S_FETCH;
        S_DRAIN: if (bus.imem_resp_valid) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (buf_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(buf_pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (default build, no bypass) with a 1/2-cycle memory model.
module tb_instr_fetch;

  bit clk;
  logic rst;
  int checks;
  int errors;

  instr_fetch_if #(.DATA_WIDTH(32)) bus ();

  instr_fetch #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: responds 1 or 2 cycles after acceptance
  bit          lat2;
  bit          p1_v;
  bit          p2_v;
  logic [31:0] p1_a;
  logic [31:0] p2_a;

  always @(posedge clk) begin
    p1_v <= bus.imem_req_valid && bus.imem_req_ready;
    p1_a <= bus.imem_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end

  assign bus.imem_resp_valid = lat2 ? p2_v : p1_v;
  assign bus.imem_resp_data  = memf(lat2 ? p2_a : p1_a);

  // Log of accepted requests and delivered instructions
  logic [31:0] req_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] dat_q[$];

  always @(negedge clk) begin
    if (bus.imem_req_valid && bus.imem_req_ready) req_q.push_back(bus.imem_addr);
    if (bus.instr_valid && bus.instr_ready) begin
      pc_q.push_back(bus.instr_pc);
      dat_q.push_back(bus.instr);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b1;
    next_cycle();
    next_cycle();
    lat2 = 1'b0;
    req_q.delete();
    pc_q.delete();
    dat_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    next_cycle();
  endtask

  task automatic test_stream();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if ((bus.imem_req_valid && bus.imem_req_ready) !== 1'b1) begin errors++; $display("FAIL stream_fire[%0d]: got %b want 1", k, bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, bus.imem_addr, 32'(4 * k)); end
      if (k < 2) begin
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d]: got %b want 0", k, bus.instr_valid); end
      end else begin
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.instr_valid); end
        checks++; if (bus.instr_pc !== 32'(4 * (k - 2))) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.instr_pc, 32'(4 * (k - 2))); end
        checks++; if (bus.instr !== memf(32'(4 * (k - 2)))) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, bus.instr, memf(32'(4 * (k - 2)))); end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int fires;
    fires = 0;
    bus.instr_ready = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) fires++;
      next_cycle();
    end
    @(negedge clk);
    checks++; if (fires !== 3) begin errors++; $display("FAIL bp_req_count: got %0d want 3", fires); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h want 0", bus.instr_pc); end
    checks++; if (req_q.size() < 3 || req_q[2] !== 32'h8) begin errors++; $display("FAIL bp_third_addr: got size %0d want addr 8", req_q.size()); end
    next_cycle();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) next_cycle();
    checks++;
    if (pc_q.size() < 5) begin
      errors++; $display("FAIL bp_drain_count: got %0d want >=5", pc_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (pc_q[i] !== 32'(4 * i) || dat_q[i] !== memf(32'(4 * i))) begin errors++; $display("FAIL bp_drain[%0d]: got pc %h data %h want pc %h", i, pc_q[i], dat_q[i], 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_redirect_drain();
    lat2 = 1'b1;
    rst = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h20;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_no_req_in_redirect: got %b want 0", bus.imem_req_valid); end
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h20) begin errors++; $display("FAIL rd_req_20: got valid %b addr %h want 1/00000020", bus.imem_req_valid, bus.imem_addr); end
    next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_no_req_redirect2: got %b want 0", bus.imem_req_valid); end
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_no_req_drain: got %b want 0", bus.imem_req_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rd_req_100: got valid %b addr %h want 1/00000100", bus.imem_req_valid, bus.imem_addr); end
    for (int k = 0; k < 5; k++) next_cycle();
    checks++; if (pc_q.size() < 1 || pc_q[0] !== 32'h100 || dat_q[0] !== memf(32'h100)) begin errors++; $display("FAIL rd_first_pc: got size %0d want first pc 00000100", pc_q.size()); end
  endtask

  task automatic test_redirect_collide();
    int n0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h8) begin errors++; $display("FAIL rc_pop_setup: got valid %b pc %h want 1/00000008", bus.instr_valid, bus.instr_pc); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rc_no_req: got %b want 0", bus.imem_req_valid); end
    next_cycle();
    bus.redirect = 1'b0;
    n0 = pc_q.size();
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rc_flushed: got %b want 0", bus.instr_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rc_req_200: got valid %b addr %h want 1/00000200", bus.imem_req_valid, bus.imem_addr); end
    next_cycle();
    for (int k = 0; k < 4; k++) next_cycle();
    checks++; if (pc_q.size() < n0 + 2 || pc_q[n0] !== 32'h200 || pc_q[n0 + 1] !== 32'h204) begin errors++; $display("FAIL rc_after_pcs: got size %0d want pcs 200,204 from index %0d", pc_q.size(), n0); end
  endtask

  task automatic test_wrap();
    int n0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    bus.redirect = 1'b0;
    n0 = pc_q.size();
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got valid %b addr %h want 1/fffffffc", bus.imem_req_valid, bus.imem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_req1: got valid %b addr %h want 1/00000000", bus.imem_req_valid, bus.imem_addr); end
    for (int k = 0; k < 4; k++) next_cycle();
    checks++; if (pc_q.size() < n0 + 2 || pc_q[n0] !== 32'hFFFF_FFFC || pc_q[n0 + 1] !== 32'h0 || dat_q[n0] !== memf(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_pcs: got size %0d want pcs fffffffc,0 from index %0d", pc_q.size(), n0); end
  endtask

  task automatic test_reset_midop();
    lat2 = 1'b1;
    bus.instr_ready = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) next_cycle();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rm_setup: got valid %b pc %h want 1/00000000", bus.instr_valid, bus.instr_pc); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req_in_rst: got %b want 0", bus.imem_req_valid); end
    next_cycle();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_after_rst: got %b want 0", bus.instr_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rm_first_req: got valid %b addr %h want 1/00000000", bus.imem_req_valid, bus.imem_addr); end
    next_cycle();
    for (int k = 0; k < 6; k++) next_cycle();
    checks++; if (pc_q.size() < 2 || pc_q[0] !== 32'h0 || pc_q[1] !== 32'h4 || dat_q[1] !== memf(32'h4)) begin errors++; $display("FAIL rm_delivered: got size %0d want pcs 0,4", pc_q.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lat2 = 1'b0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    next_cycle();
    test_reset();
    test_stream();
    apply_reset();
    test_backpressure();
    apply_reset();
    test_redirect_drain();
    apply_reset();
    test_redirect_collide();
    test_wrap();
    apply_reset();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the producer side of the decode stage's `instr` input. It holds the program counter and issues word requests to instruction memory over a valid/ready request channel. Returned words are buffered in a small FIFO and handed to decode with their PC over a valid/ready output channel. Taken branches and jumps (PCSrc plus computed target) redirect the PC, flush the buffer and discard any in-flight response.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC, addresses and instruction words
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `BUF_DEPTH`, 2, instruction buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_addr`  out  DATA_WIDTH  word address of request, bits [1:0] always 0
- `imem_resp_valid`  in  1  response word valid (exactly one per accepted request, in order, ≥1 cycle after acceptance)
- `imem_resp_data`  in  DATA_WIDTH  fetched instruction word
- `instr_valid`  out  1  `instr`/`instr_pc` valid to decode
- `instr_ready`  in  1  decode consumes this cycle
- `instr`  out  DATA_WIDTH  instruction word to decode
- `instr_pc`  out  DATA_WIDTH  address of `instr`
- `redirect`  in  1  taken branch/jump (PCSrc)
- `redirect_pc`  in  DATA_WIDTH  new fetch address; bits [1:0] ignored, treated as 0

## Operation
- At most one outstanding memory request. The PC register `fetch_pc` drives `imem_addr`.
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding, response kept.
  - DRAIN: one request outstanding, response to be discarded.
- `imem_req_valid` = (state==FETCH or (state==WAIT and imem_resp_valid)) and free slot. Free slot means buffer count < BUF_DEPTH after accounting for this cycle's pop.
- Request handshake (`valid & ready`): `fetch_pc += 4` (wraps modulo 2^DATA_WIDTH); state → WAIT; the pending entry's PC is recorded.
- WAIT + `imem_resp_valid`: push {data, recorded PC}; state → FETCH, or stays WAIT if a new request is accepted the same cycle.
- DRAIN + `imem_resp_valid`: drop data; state → FETCH.
- Buffer pops on `instr_valid & instr_ready`. Push and pop in the same cycle are allowed; this includes the full buffer case when the pop frees the slot.
- `redirect` (priority over everything above):
  - `fetch_pc` ← {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
  - Buffer flushed (count 0), and the same-cycle pop and push are void.
  - If a request is outstanding, or is accepted this cycle, state → DRAIN; else → FETCH.
  - No new request is issued in the redirect cycle.
- `redirect` while in DRAIN: PC updated, state stays DRAIN. If the response arrives in the same cycle, state → FETCH.
- No request is ever dropped by the fetch unit once `imem_req_valid` is high without a redirect. `imem_addr` is stable while valid and not ready.

## Timing
- Reset values (while `rst`=1 and the cycle after): `fetch_pc`=RESET_PC, state FETCH, buffer empty. `imem_req_valid`=0 while `rst`=1. `instr_valid`=0, `instr`=0, `instr_pc`=0.
- First request: the first cycle with `rst`=0, `imem_addr`=RESET_PC.
- `rst` mid-operation: buffer and FSM cleared the next edge. An outstanding response arriving after reset is ignored (state FETCH).
- Latency, response to `instr_valid`: 1 cycle (registered buffer) unless bypass is enabled.
- Throughput: with 1-cycle memory and `instr_ready`=1, one instruction per cycle in steady state.
- Redirect to first new request: the cycle after the redirect in FETCH, or the cycle after the discarded response in DRAIN.

## Configuration
- `FETCH_BYPASS_EN` defined: when the buffer is empty, a kept response drives `instr`/`instr_pc`/`instr_valid` combinationally in the same cycle. If `instr_ready`=1, it is not written to the buffer; zero-cycle fetch-to-decode latency.
- Undefined: all responses go through the buffer; outputs are purely registered; 1-cycle latency.

## Test plan
- Reset, RESET_PC=0, memory always ready, 1-cycle response, `instr_ready`=1 → addresses 0,4,8,12 on consecutive cycles. `instr_pc` 0,4,8 follows with its data, one per cycle from the second cycle after reset release.
- `instr_ready`=0 for 10 cycles → exactly BUF_DEPTH+1 requests issued, then `imem_req_valid`=0. On release, the words drain in order with no loss or duplication.
- Request accepted to 0x20, `redirect`=1 with `redirect_pc`=0x103 before the response → that response is discarded. The next request is to 0x100, and the first `instr_pc` after the redirect is 0x100.
- `redirect` in the same cycle as `instr_valid & instr_ready` and a response → buffer empty next cycle, and the response is not delivered.
- `redirect_pc`=0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000.
- `rst` asserted with 2 buffered words and a request outstanding → `instr_valid`=0 next cycle. The late response is ignored, and the first request after release is RESET_PC.
